// File: rtl/vector_load_unit.sv
// Byte-serial load engine: fetches 1 (scalar) or LANES (vector) bytes and issues one register-file write.
// Latency start->WE3 is N+2 cycles; start while busy is dropped, illegal dest pulses err with no access.
module vector_load_unit #(
    parameter int LANES = 6,
    parameter int AW    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [AW-1:0]      base_addr,
    input  logic [3:0]         dest,
    input  logic               sflag,
    output logic [AW-1:0]      mem_addr,
    output logic               mem_re,
    input  logic [7:0]         mem_rdata,
    output logic               busy,
    output logic               WE3,
    output logic               LDFlag,
    output logic               SFlag,
    output logic [3:0]         A3,
    output logic [LANES*8-1:0] WD3,
    output logic               err
);

    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, last_idx, rd_idx;
    logic               rd_vld, sflag_q, illegal, accept;
    logic [3:0]         dest_q;
    logic [LANES*8-1:0] lanes, lanes_nxt;

    assign illegal  = sflag ? (dest > 4'(LANES - 1)) : (dest == 4'hF);
    assign accept   = (state == IDLE) && start && !illegal;
    assign last_idx = sflag_q ? '0 : CW'(LANES - 1);
    assign busy     = (state != IDLE);
    assign WE3      = (state == WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = FETCH;
            FETCH:   if (cnt == last_idx) state_nxt = DRAIN;
            DRAIN:   state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rd_vld/rd_idx trail the issued read by one cycle, matching the memory's read latency
    always_comb begin
        lanes_nxt = lanes;
        for (int i = 0; i < LANES; i++) begin
            if (rd_vld && (rd_idx == CW'(i))) lanes_nxt[i*8 +: 8] = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rd_idx   <= '0;
            rd_vld   <= 1'b0;
            sflag_q  <= 1'b0;
            dest_q   <= '0;
            lanes    <= '0;
            mem_addr <= '0;
            mem_re   <= 1'b0;
            LDFlag   <= 1'b0;
            SFlag    <= 1'b0;
            A3       <= '0;
            WD3      <= '0;
            err      <= 1'b0;
        end else begin
            err    <= (state == IDLE) && start && illegal;
            rd_vld <= (state == FETCH);
            rd_idx <= cnt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sflag_q  <= sflag;
                        dest_q   <= dest;
                        cnt      <= '0;
                        mem_addr <= base_addr;
                        mem_re   <= 1'b1;
                        lanes    <= '0;
                    end
                end
                FETCH: begin
                    lanes <= lanes_nxt;
                    if (cnt == last_idx) begin
                        mem_re <= 1'b0;
                    end else begin
                        cnt      <= cnt + CW'(1);
                        mem_addr <= mem_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    lanes  <= lanes_nxt;
                    WD3    <= lanes_nxt;
                    A3     <= dest_q;
                    SFlag  <= sflag_q;
                    LDFlag <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/vector_load_unit.md
# vector_load_unit

Multi-cycle load engine feeding the vector register file's write port. On a load request it reads one byte (scalar load) or six consecutive bytes (vector load) from the byte-wide synchronous data memory. It packs them into a 6-lane × 8-bit word and issues a single-cycle write (WE3/A3/WD3 with SFlag/LDFlag) to the register file. It sits between the execute-stage load decode and the register file write port.

## Interface
Parameters:
- LANES, 6, vector lanes per register; sets the vector-load byte count.
- AW, 16, data memory address width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  load request; sampled only when busy=0.
- base_addr  in  AW  address of byte 0 of the load.
- dest  in  4  destination index: scalar lane 0..5 when sflag=1, vector register 0..14 when sflag=0.
- sflag  in  1  1 = scalar load (1 byte), 0 = vector load (LANES bytes).
- mem_addr  out  AW  data memory read address.
- mem_re  out  1  memory read enable.
- mem_rdata  in  8  read data; valid exactly 1 cycle after the address is presented.
- busy  out  1  high while a load is in progress.
- WE3  out  1  register file write-enable pulse.
- LDFlag  out  1  marks the write as a load; asserted together with WE3.
- SFlag  out  1  scalar-write flag presented with WE3.
- A3  out  4  destination index presented with WE3.
- WD3  out  LANES×8  packed write data; lane i = WD3[8i+7:8i].
- err  out  1  one-cycle pulse on a rejected request.

## Operation
- FSM states:
  - IDLE: latch base_addr, dest and sflag when start=1; N = 1 if sflag else LANES.
  - FETCH: cnt = 0..N−1; drive mem_addr = base_addr + cnt (mod 2^AW) and mem_re = 1.
  - DRAIN: capture the final byte.
  - WRITE: pulse WE3.
  - Then return to IDLE.
- Capture: a delayed valid flag tracks each issued read. The byte returned for address base+i is stored in lane i. Unloaded lanes are 0; for a scalar load, lanes 1..5 = 0.
- Scalar load: WD3[7:0] = byte, SFlag = 1, LDFlag = 1, A3 = dest.
- Vector load: SFlag = 0, LDFlag = 1, A3 = dest.
- Rejected requests (err = 1 for one cycle, no memory access, stays IDLE):
  - sflag = 1 with dest > 5.
  - sflag = 0 with dest = 15.
- start while busy = 1 is ignored; no queueing.
- A3, WD3, SFlag and LDFlag are registered and hold their last value after WRITE. LDFlag and SFlag are valid only while WE3 = 1.
- mem_addr holds its last value outside FETCH; mem_re = 0 outside FETCH.

## Timing
- Reset values (asynchronous, immediate):
  - State = IDLE, cnt = 0.
  - busy, mem_re, WE3, LDFlag, SFlag, err = 0.
  - mem_addr = 0, A3 = 0, WD3 = 0.
- Reset mid-load: the load is abandoned, no WE3 is issued, and captured lanes are cleared.
- Start is accepted at edge 0; busy = 1 from cycle 1.
- Vector load:
  - FETCH in cycles 1–6, DRAIN in cycle 7, WRITE in cycle 8 (WE3 = 1).
  - IDLE in cycle 9; busy = 0 and a new start can be accepted in cycle 9.
  - Latency from start to WE3 is 8 cycles.
- Scalar load:
  - FETCH in cycle 1, DRAIN in cycle 2, WRITE in cycle 3.
  - Latency is 3 cycles.
- WE3 is exactly one cycle wide per accepted load. busy falls in the cycle after WE3.
- Address wrap: base_addr = 2^AW−2 with a vector load reads FFFE, FFFF, 0000, 0001, 0002, 0003.

## Test plan
- Vector load, base 0x0010, dest 7; memory 0x10..0x15 = 11,22,33,44,55,66 -> cycle 8: WE3 = 1, A3 = 7, SFlag = 0, LDFlag = 1, WD3 = 66_55_44_33_22_11 (lane 5..0); mem_addr sequence 0x10..0x15 in cycles 1–6.
- Scalar load, base 0x0040 = 0xA5, dest 3 -> cycle 3: WE3 = 1, SFlag = 1, A3 = 3, WD3 = 0x0000000000A5; busy high in cycles 1–3 only.
- Wrap-around: vector load at base 0xFFFE -> mem_addr FFFE, FFFF, 0000, 0001, 0002, 0003; lane order preserved.
- Illegal requests: scalar with dest 6, then vector with dest 15 -> err pulses one cycle each; no mem_re, no WE3, busy stays 0.
- start held high continuously during a vector load -> second load accepted in cycle 9, its WE3 in cycle 17; no extra WE3 in between.
- rst asserted in cycle 4 of a vector load -> outputs return to reset values immediately; no WE3 after release; a fresh load afterwards completes correctly.
